irq_sequencer: RTL and testbench

- Multi-source interrupt sequencer for the 5-stage RISC pipeline.
- Sits beside fetch. It latches edge-triggered requests from NUM_IRQ sources, arbitrates by fixed priority, and drains or holds the in-flight instruction correctly (multi-word, jump).
- It then injects the two-part interrupt instruction pair carrying the return PC, and redirects fetch to the winning source's IVT slot.
- Successor to the single-source interrupt handler: adds N sources, per-source masking, pending latching, acknowledge, and a parametrised vector table.

---
 rtl/irq_pkg.sv | 24 ++
 rtl/irq_sequencer_if.sv | 35 +++
 rtl/irq_priority_arbiter.sv | 25 ++
 rtl/irq_sequencer.sv | 121 ++++++++++++
 tb/tb_irq_sequencer.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/irq_pkg.sv
// Shared types and encodings for the interrupt sequencer.
package irq_pkg;

  typedef enum logic [2:0] {
    IDLE, SKIP, JWAIT, BUBBLE, PART1, PART2, REDIRECT
  } state_t;

  typedef enum logic [1:0] {CLS_NORMAL, CLS_MULTI, CLS_JMP} cls_t;

  localparam logic [15:0] BUBBLE_INSTR = 16'h07F8;
  localparam logic [15:0] INT_PART1    = 16'hF480;
  localparam logic [15:0] INT_PART2    = 16'hF481;
  localparam logic [4:0]  OP_LDM       = 5'b11000;
  localparam logic [4:0]  OP_CALL      = 5'b11010;
  localparam logic [2:0]  FUNC_IMM     = 3'b100;

  // Multi-word instructions must finish before injecting, so they outrank jumps.
  function automatic cls_t classify(logic [4:0] op, logic [2:0] func, logic jmp);
    if (func == FUNC_IMM || op == OP_CALL || op == OP_LDM) return CLS_MULTI;
    else if (jmp)                                          return CLS_JMP;
    else                                                   return CLS_NORMAL;
  endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Fetch-side bundle between the pipeline (master) and the sequencer (slave).
interface irq_sequencer_if #(
  parameter int NUM_IRQ = 4,
  parameter int PC_W    = 32,
  parameter int INSTR_W = 16
);
  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] irq_mask;
  logic [4:0]         fetch_opcode;
  logic [2:0]         fetch_func;
  logic               is_jmp;
  logic [PC_W-1:0]    next_pc;
  logic               busy;
  logic               inject_valid;
  logic               inject_bubble;
  logic [INSTR_W-1:0] inject_instr;
  logic               save_pc_valid;
  logic [PC_W-1:0]    save_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_addr;
  logic [NUM_IRQ-1:0] irq_ack;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq, irq_mask, fetch_opcode, fetch_func, is_jmp, next_pc,
    input  busy, inject_valid, inject_bubble, inject_instr, save_pc_valid,
           save_pc, redirect_valid, redirect_addr, irq_ack, pending
  );

  modport slave (
    input  irq, irq_mask, fetch_opcode, fetch_func, is_jmp, next_pc,
    output busy, inject_valid, inject_bubble, inject_instr, save_pc_valid,
           save_pc, redirect_valid, redirect_addr, irq_ack, pending
  );
endinterface

// File: rtl/irq_priority_arbiter.sv
// Combinational fixed-priority pick: lowest set index wins.
module irq_priority_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  output logic             o_found,
  output logic [IDX_W-1:0] o_idx,
  output logic [N-1:0]     o_onehot
);
  always_comb begin
    o_found  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    // Scan high to low so the lowest requester is the last writer.
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_found     = 1'b1;
        o_idx       = IDX_W'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/irq_sequencer.sv
// Multi-source interrupt sequencer: latches edges, arbitrates, drains fetch,
// injects the interrupt pair and redirects fetch to the IVT slot.
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int          NUM_IRQ  = 4,
  parameter int          PC_W     = 32,
  parameter int          INSTR_W  = 16,
  parameter int unsigned IVT_BASE = 0
) (
  input  logic            clk,
  input  logic            rst,
  irq_sequencer_if.slave  bus
);
  localparam int IRQ_IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  state_t                 r_state, w_next;
  logic [NUM_IRQ-1:0]     r_pending, r_irq_prev, r_ack;
  logic [NUM_IRQ-1:0]     w_req, w_cand, w_clear, w_arb_onehot;
  logic [IRQ_IDX_W-1:0]   r_idx, w_arb_idx;
  logic [PC_W-1:0]        r_saved;
  logic                   w_found;
  cls_t                   w_cls;

  assign w_req  = bus.irq & ~r_irq_prev;
  assign w_cand = r_pending & ~bus.irq_mask;
  assign w_cls  = classify(bus.fetch_opcode, bus.fetch_func, bus.is_jmp);
  assign bus.pending = r_pending;

  irq_priority_arbiter #(.N(NUM_IRQ), .IDX_W(IRQ_IDX_W)) u_arb (
    .i_req    (w_cand),
    .o_found  (w_found),
    .o_idx    (w_arb_idx),
    .o_onehot (w_arb_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_pending  <= '0;
      r_irq_prev <= '0;
      r_ack      <= '0;
      r_idx      <= '0;
      r_saved    <= '0;
    end else begin
      r_state    <= w_next;
      r_irq_prev <= bus.irq;
      // A fresh edge on the source being acked re-arms it.
      r_pending  <= (r_pending & ~w_clear) | w_req;
      if (r_state == IDLE && w_found) begin
        r_idx   <= w_arb_idx;
        r_ack   <= w_arb_onehot;
        r_saved <= (w_cls == CLS_MULTI) ? bus.next_pc + PC_W'(1) : bus.next_pc;
      end
      if (r_state == JWAIT) r_saved <= bus.next_pc;
    end
  end

  always_comb begin
    w_next             = r_state;
    w_clear            = '0;
    bus.busy           = 1'b0;
    bus.inject_valid   = 1'b0;
    bus.inject_bubble  = 1'b0;
    bus.inject_instr   = '0;
    bus.save_pc_valid  = 1'b0;
    bus.save_pc        = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.irq_ack        = '0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          case (w_cls)
            CLS_MULTI: w_next = SKIP;
            CLS_JMP:   w_next = JWAIT;
            default:   w_next = BUBBLE;
          endcase
        end
      end
      SKIP: begin
        bus.busy = 1'b1;
        w_next   = BUBBLE;
      end
      JWAIT: begin
        bus.busy = 1'b1;
        w_next   = PART1;
      end
      BUBBLE: begin
        bus.busy          = 1'b1;
        bus.inject_valid  = 1'b1;
        bus.inject_bubble = 1'b1;
        bus.inject_instr  = INSTR_W'(BUBBLE_INSTR);
        w_next            = PART1;
      end
      PART1: begin
        bus.busy          = 1'b1;
        bus.inject_valid  = 1'b1;
        bus.inject_instr  = INSTR_W'(INT_PART1);
        bus.save_pc_valid = 1'b1;
        bus.save_pc       = r_saved;
        w_next            = PART2;
      end
      PART2: begin
        bus.busy         = 1'b1;
        bus.inject_valid = 1'b1;
        bus.inject_instr = INSTR_W'(INT_PART2);
        w_next           = REDIRECT;
      end
      REDIRECT: begin
        bus.busy           = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_addr  = PC_W'(IVT_BASE) + PC_W'(r_idx);
        bus.irq_ack        = r_ack;
        w_clear            = r_ack;
        w_next             = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_irq_sequencer.sv
// Directed checks of the interrupt sequencer with hand-computed expectations.
module tb_irq_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  irq_sequencer_if #(.NUM_IRQ(4), .PC_W(32), .INSTR_W(16)) bus ();

  irq_sequencer #(.NUM_IRQ(4), .PC_W(32), .INSTR_W(16), .IVT_BASE(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Payload fields are only compared when their valid is expected high.
  task automatic chk_out(input string tag, input logic b, input logic iv, input logic ib,
                         input logic [15:0] ins, input logic spv, input logic [31:0] spc,
                         input logic rv, input logic [31:0] ra, input logic [3:0] ack);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".inj_v"}, 32'(bus.inject_valid), 32'(iv));
    chk({tag, ".inj_b"}, 32'(bus.inject_bubble), 32'(ib));
    chk({tag, ".spc_v"}, 32'(bus.save_pc_valid), 32'(spv));
    chk({tag, ".rdr_v"}, 32'(bus.redirect_valid), 32'(rv));
    chk({tag, ".ack"}, 32'(bus.irq_ack), 32'(ack));
    if (iv)  chk({tag, ".instr"}, 32'(bus.inject_instr), 32'(ins));
    if (spv) chk({tag, ".save_pc"}, bus.save_pc, spc);
    if (rv)  chk({tag, ".rdr_addr"}, bus.redirect_addr, ra);
  endtask

  task automatic chk_idle(input string tag);
    chk_out(tag, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'b0);
    chk({tag, ".instr0"}, 32'(bus.inject_instr), 32'h0);
    chk({tag, ".spc0"}, bus.save_pc, 32'h0);
    chk({tag, ".rdr0"}, bus.redirect_addr, 32'h0);
  endtask

  initial begin
    bus.irq = '0; bus.irq_mask = '0; bus.fetch_opcode = 5'b00000;
    bus.fetch_func = 3'b000; bus.is_jmp = 1'b0; bus.next_pc = 32'h100;
    step(); step();
    chk_idle("rst");
    chk("rst.pending", 32'(bus.pending), 32'h0);
    rst = 1'b0;

    // NORMAL: source 2, ADD in fetch
    bus.irq = 4'b0100;
    step(); chk("n.pend", 32'(bus.pending), 32'h4); chk("n.idle_busy", 32'(bus.busy), 32'h0);
    step(); chk_out("n.bub", 1, 1, 1, 16'h07F8, 0, 0, 0, 0, 4'b0);
    step(); chk_out("n.p1", 1, 1, 0, 16'hF480, 1, 32'h100, 0, 0, 4'b0);
    step(); chk_out("n.p2", 1, 1, 0, 16'hF481, 0, 0, 0, 0, 4'b0);
    step(); chk_out("n.rdr", 1, 0, 0, 16'h0, 0, 0, 1, 32'h2, 4'b0100);
    step(); chk_idle("n.done"); chk("n.clr", 32'(bus.pending), 32'h0);
    bus.irq = '0; step();

    // MULTI: source 0 with immediate function bits
    bus.irq = 4'b0001; bus.fetch_func = 3'b100; bus.next_pc = 32'h200;
    step();
    step(); chk_out("m.skip", 1, 0, 0, 16'h0, 0, 0, 0, 0, 4'b0);
    bus.fetch_func = 3'b000;
    step(); chk_out("m.bub", 1, 1, 1, 16'h07F8, 0, 0, 0, 0, 4'b0);
    step(); chk_out("m.p1", 1, 1, 0, 16'hF480, 1, 32'h201, 0, 0, 4'b0);
    step(); chk_out("m.p2", 1, 1, 0, 16'hF481, 0, 0, 0, 0, 4'b0);
    step(); chk_out("m.rdr", 1, 0, 0, 16'h0, 0, 0, 1, 32'h0, 4'b0001);
    bus.irq = '0; step(); chk_idle("m.done");

    // JMP: source 1, target resolves during the wait cycle
    bus.irq = 4'b0010; bus.is_jmp = 1'b1; bus.next_pc = 32'h340;
    step();
    step(); chk_out("j.wait", 1, 0, 0, 16'h0, 0, 0, 0, 0, 4'b0);
    bus.is_jmp = 1'b0; bus.next_pc = 32'h350;
    step(); chk_out("j.p1", 1, 1, 0, 16'hF480, 1, 32'h350, 0, 0, 4'b0);
    step(); chk_out("j.p2", 1, 1, 0, 16'hF481, 0, 0, 0, 0, 4'b0);
    step(); chk_out("j.rdr", 1, 0, 0, 16'h0, 0, 0, 1, 32'h1, 4'b0010);
    bus.irq = '0; step(); chk_idle("j.done");

    // Priority/mask: 3 and 1 together, 1 masked
    bus.irq = 4'b1010; bus.irq_mask = 4'b0010; bus.next_pc = 32'h400;
    step();
    step(); chk_out("pm.bub", 1, 1, 1, 16'h07F8, 0, 0, 0, 0, 4'b0);
    chk("pm.pend", 32'(bus.pending), 32'hA);
    step(); step();
    step(); chk_out("pm.rdr3", 1, 0, 0, 16'h0, 0, 0, 1, 32'h3, 4'b1000);
    bus.irq_mask = '0;
    step(); chk("pm.idle", 32'(bus.busy), 32'h0); chk("pm.pend1", 32'(bus.pending), 32'h2);
    step(); chk_out("pm.bub1", 1, 1, 1, 16'h07F8, 0, 0, 0, 0, 4'b0);
    step(); chk_out("pm.p1", 1, 1, 0, 16'hF480, 1, 32'h400, 0, 0, 4'b0);
    step();
    step(); chk_out("pm.rdr1", 1, 0, 0, 16'h0, 0, 0, 1, 32'h1, 4'b0010);
    bus.irq = '0; step(); chk("pm.clr", 32'(bus.pending), 32'h0);

    // Pending while busy: source 0 rises during PART1 of source 2
    bus.irq = 4'b0100; bus.next_pc = 32'h100;
    step(); step();
    step(); bus.irq = 4'b0101;
    step(); chk_out("pb.p2", 1, 1, 0, 16'hF481, 0, 0, 0, 0, 4'b0);
    chk("pb.pend", 32'(bus.pending), 32'h5);
    step(); chk_out("pb.rdr2", 1, 0, 0, 16'h0, 0, 0, 1, 32'h2, 4'b0100);
    step(); chk("pb.idle", 32'(bus.busy), 32'h0); chk("pb.pend0", 32'(bus.pending), 32'h1);
    step(); chk_out("pb.bub0", 1, 1, 1, 16'h07F8, 0, 0, 0, 0, 4'b0);
    step(); step();
    step(); chk_out("pb.rdr0", 1, 0, 0, 16'h0, 0, 0, 1, 32'h0, 4'b0001);
    bus.irq = '0; step();

    // next_pc+1 wraps at all-ones on a MULTI (LDM opcode)
    bus.irq = 4'b1000; bus.fetch_opcode = 5'b11000; bus.next_pc = 32'hFFFF_FFFF;
    step();
    step(); chk_out("w.skip", 1, 0, 0, 16'h0, 0, 0, 0, 0, 4'b0);
    bus.fetch_opcode = 5'b00000;
    step();
    step(); chk_out("w.p1", 1, 1, 0, 16'hF480, 1, 32'h0, 0, 0, 4'b0);
    step();
    step(); chk_out("w.rdr", 1, 0, 0, 16'h0, 0, 0, 1, 32'h3, 4'b1000);
    bus.irq = '0; bus.next_pc = 32'h100; step();

    // Reset during PART2 aborts without ack
    bus.irq = 4'b1000;
    step(); step(); step();
    step(); chk_out("r.p2", 1, 1, 0, 16'hF481, 0, 0, 0, 0, 4'b0);
    rst = 1'b1; bus.irq = '0;
    step(); chk_idle("r.rst"); chk("r.pend", 32'(bus.pending), 32'h0);
    rst = 1'b0;
    step(); chk_idle("r.after"); chk("r.pend2", 32'(bus.pending), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
